// File: rtl/i2s_mix_engine_if.sv
// Bus bundle between the mixing core and its surroundings: sample capture,
// gain configuration handshake, mixed sample banks and status flags.
interface i2s_mix_engine_if #(
  parameter int N_CH = 4,
  parameter int DW   = 16,
  parameter int GW   = 8
);
  localparam int CW = $clog2(N_CH);

  logic                 ws;
  logic [N_CH*DW-1:0]   rx_data;
  logic                 bypass;
  logic                 cfg_we;
  logic                 cfg_ready;
  logic [CW-1:0]        cfg_out;
  logic [CW-1:0]        cfg_in;
  logic [GW-1:0]        cfg_gain;
  logic                 sat_clr;
  logic [N_CH*DW-1:0]   mix_left;
  logic [N_CH*DW-1:0]   mix_right;
  logic                 mix_valid;
  logic                 mix_side;
  logic                 busy;
  logic                 sat_flag;
  logic                 overrun;

  modport master (
    output ws, rx_data, bypass, cfg_we, cfg_out, cfg_in, cfg_gain, sat_clr,
    input  cfg_ready, mix_left, mix_right, mix_valid, mix_side, busy,
           sat_flag, overrun
  );

  modport slave (
    input  ws, rx_data, bypass, cfg_we, cfg_out, cfg_in, cfg_gain, sat_clr,
    output cfg_ready, mix_left, mix_right, mix_valid, mix_side, busy,
           sat_flag, overrun
  );
endinterface

// File: rtl/i2s_mix_engine.sv
// N-codec stereo mixing core. Each ws edge captures one sample per codec,
// runs a sequential MAC over the gain matrix, saturates each row result and
// publishes the whole bank for that side in one cycle.
//
// state | meaning
// IDLE  | waiting for a ws edge; gain writes go straight to the matrix
// MAC   | accumulate in_buf[j] * gain[i][j] for the current row i
// STORE | scale and clamp row i into the shadow bank
// DONE  | copy shadow bank to the left/right outputs, pulse mix_valid
module i2s_mix_engine #(
  parameter int N_CH = 4,
  parameter int DW   = 16,
  parameter int GW   = 8
) (
  input  logic               clk,
  input  logic               nRst,
  i2s_mix_engine_if.slave    mix_bus
);
  localparam int CW = $clog2(N_CH);
  localparam int AW = DW + GW + CW + 1;
  localparam int PW = DW + GW + 1;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
  localparam logic [GW-1:0] UNITY = {1'b1, {(GW-1){1'b0}}};
  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t                r_state;
  logic                  r_ws_d;
  logic [DW-1:0]         r_in_buf [N_CH];
  logic [DW-1:0]         r_shadow [N_CH];
  logic [GW-1:0]         r_gain   [N_CH][N_CH];
  logic                  r_side;
  logic                  r_byp;
  logic signed [AW-1:0]  r_acc;
  logic [CW-1:0]         r_i;
  logic [CW-1:0]         r_j;
  logic [N_CH*DW-1:0]    r_mix_left;
  logic [N_CH*DW-1:0]    r_mix_right;
  logic                  r_mix_valid;
  logic                  r_mix_side;
  logic                  r_busy;
  logic                  r_sat;
  logic                  r_ovr;
  logic                  r_cfg_ready;
  logic                  r_pend;
  logic [CW-1:0]         r_pend_out;
  logic [CW-1:0]         r_pend_in;
  logic [GW-1:0]         r_pend_gain;

  logic                  w_edge;
  logic [GW-1:0]         w_gain_sel;
  logic signed [PW-1:0]  w_x_ext;
  logic signed [PW-1:0]  w_g_ext;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_acc_next;
  logic signed [AW-1:0]  w_shift;
  logic                  w_hi;
  logic                  w_lo;
  logic [DW-1:0]         w_sat_val;
  logic                  w_sat_set;
  logic                  w_ovr_set;
  logic                  w_cfg_acc;
  logic                  w_direct;
  logic [N_CH*DW-1:0]    w_shadow_flat;

  assign w_edge    = (mix_bus.ws != r_ws_d);
  assign w_ovr_set = w_edge && (r_state != IDLE);
  assign w_cfg_acc = mix_bus.cfg_we && r_cfg_ready;
  assign w_direct  = w_cfg_acc && (r_state == IDLE) && !w_edge;

  // Bypass forces an identity matrix for the frame without touching r_gain.
  assign w_gain_sel = r_byp ? ((r_i == r_j) ? UNITY : '0) : r_gain[r_i][r_j];
  assign w_x_ext    = {{(GW+1){r_in_buf[r_j][DW-1]}}, r_in_buf[r_j]};
  assign w_g_ext    = {{(DW+1){1'b0}}, w_gain_sel};
  assign w_prod     = w_x_ext * w_g_ext;
  assign w_acc_next = r_acc + {{CW{w_prod[PW-1]}}, w_prod};

  // Gains are Q1.(GW-1): drop the fraction with a flooring shift, then clamp.
  assign w_shift   = r_acc >>> (GW - 1);
  assign w_hi      = (w_shift > SMAX);
  assign w_lo      = (w_shift < SMIN);
  assign w_sat_val = w_hi ? SMAX[DW-1:0] : (w_lo ? SMIN[DW-1:0] : w_shift[DW-1:0]);
  assign w_sat_set = (r_state == STORE) && (w_hi || w_lo);

  // Flatten the shadow bank into lane order for the atomic publish.
  always_comb begin
    w_shadow_flat = '0;
    for (int k = 0; k < N_CH; k++) w_shadow_flat[k*DW +: DW] = r_shadow[k];
  end

  // Frame sequencer, MAC datapath, output banks and sticky status flags.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state     <= IDLE;
      r_ws_d      <= 1'b0;
      r_side      <= 1'b0;
      r_byp       <= 1'b0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_mix_left  <= '0;
      r_mix_right <= '0;
      r_mix_valid <= 1'b0;
      r_mix_side  <= 1'b0;
      r_busy      <= 1'b0;
      r_sat       <= 1'b0;
      r_ovr       <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_in_buf[k] <= '0;
        r_shadow[k] <= '0;
      end
    end else begin
      r_ws_d      <= mix_bus.ws;
      r_mix_valid <= 1'b0;
      r_sat       <= w_sat_set || (r_sat && !mix_bus.sat_clr);
      r_ovr       <= w_ovr_set || (r_ovr && !mix_bus.sat_clr);
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            for (int k = 0; k < N_CH; k++) r_in_buf[k] <= mix_bus.rx_data[k*DW +: DW];
            r_side  <= mix_bus.ws;
            r_byp   <= mix_bus.bypass;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          if (r_j == LAST) r_state <= STORE;
          else r_j <= r_j + CW'(1);
        end
        STORE: begin
          r_shadow[r_i] <= w_sat_val;
          r_acc         <= '0;
          r_j           <= '0;
          if (r_i == LAST) begin
            r_state <= DONE;
          end else begin
            r_i     <= r_i + CW'(1);
            r_state <= MAC;
          end
        end
        DONE: begin
          if (r_side) r_mix_left <= w_shadow_flat;
          else r_mix_right <= w_shadow_flat;
          r_mix_valid <= 1'b1;
          r_mix_side  <= r_side;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gain matrix and write handshake; a frame in flight never sees new gains.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_cfg_ready <= 1'b1;
      r_pend      <= 1'b0;
      r_pend_out  <= '0;
      r_pend_in   <= '0;
      r_pend_gain <= '0;
      for (int k = 0; k < N_CH; k++)
        for (int m = 0; m < N_CH; m++)
          r_gain[k][m] <= (k == m) ? UNITY : '0;
    end else if (r_pend) begin
      if (r_state == IDLE) begin
        r_gain[r_pend_out][r_pend_in] <= r_pend_gain;
        r_pend      <= 1'b0;
        r_cfg_ready <= 1'b1;
      end
    end else if (w_direct) begin
      r_gain[mix_bus.cfg_out][mix_bus.cfg_in] <= mix_bus.cfg_gain;
    end else if (w_cfg_acc) begin
      r_pend      <= 1'b1;
      r_pend_out  <= mix_bus.cfg_out;
      r_pend_in   <= mix_bus.cfg_in;
      r_pend_gain <= mix_bus.cfg_gain;
      r_cfg_ready <= 1'b0;
    end
  end

  assign mix_bus.mix_left  = r_mix_left;
  assign mix_bus.mix_right = r_mix_right;
  assign mix_bus.mix_valid = r_mix_valid;
  assign mix_bus.mix_side  = r_mix_side;
  assign mix_bus.busy      = r_busy;
  assign mix_bus.sat_flag  = r_sat;
  assign mix_bus.overrun   = r_ovr;
  assign mix_bus.cfg_ready = r_cfg_ready;
endmodule
